// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encoding, lamp codes and sequencing helper for the traffic controller
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_G1    = 3'd0,
        PH_Y1    = 3'd1,
        PH_AR1   = 3'd2,
        PH_G2    = 3'd3,
        PH_Y2    = 3'd4,
        PH_AR2   = 3'd5,
        PH_FLASH = 3'd6,
        PH_BAD   = 3'd7
    } phase_e;

    // Per-road lamp triple, ordered {R, Y, G}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Day-cycle successor; night entry and flash exit are overlaid by the controller
    function automatic phase_e next_phase(input phase_e ph, input logic allred_en);
        case (ph)
            PH_G1:   return PH_Y1;
            PH_Y1:   return allred_en ? PH_AR1 : PH_G2;
            PH_AR1:  return PH_G2;
            PH_G2:   return PH_Y2;
            PH_Y2:   return allred_en ? PH_AR2 : PH_G1;
            PH_AR2:  return PH_G1;
            default: return PH_AR2;
        endcase
    endfunction

    function automatic logic is_green(input phase_e ph);
        return (ph == PH_G1) || (ph == PH_G2);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter shared by all phases; never wraps below zero
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/traffic_ctrl_param.sv
// rtl/traffic_ctrl_param.sv - two-road traffic-light controller with all-red, pedestrian and night modes
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int T_GREEN1  = 40,
    parameter int T_GREEN2  = 45,
    parameter int T_YELLOW  = 5,
    parameter int T_ALLRED  = 2,
    parameter int T_PED_REM = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             night_mode,
    input  logic             ped_req,
    output logic             R1,
    output logic             Y1,
    output logic             G1,
    output logic             R2,
    output logic             Y2,
    output logic             G2,
    output logic [CNT_W-1:0] remain,
    output logic [2:0]       phase
);

    localparam logic             ALLRED_EN = (T_ALLRED != 0);
    localparam logic [CNT_W-1:0] LD_G1     = CNT_W'(T_GREEN1 - 1);
    localparam logic [CNT_W-1:0] LD_G2     = CNT_W'(T_GREEN2 - 1);
    localparam logic [CNT_W-1:0] LD_Y      = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_AR     = ALLRED_EN ? CNT_W'(T_ALLRED - 1) : '0;
    localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(T_PED_REM - 1);
    localparam phase_e           RST_PH    = ALLRED_EN ? PH_AR2 : PH_G1;
    localparam logic [CNT_W-1:0] RST_REM   = ALLRED_EN ? LD_AR : LD_G1;

    function automatic logic [CNT_W-1:0] load_value(input phase_e ph);
        case (ph)
            PH_G1:         return LD_G1;
            PH_G2:         return LD_G2;
            PH_Y1, PH_Y2:  return LD_Y;
            PH_AR1, PH_AR2: return LD_AR;
            default:       return '0;
        endcase
    endfunction

    // Lamp word {R1,Y1,G1,R2,Y2,G2}; anything unexpected shows all red
    function automatic logic [5:0] lamp_of(input phase_e ph, input logic fl);
        case (ph)
            PH_G1:          return {LAMP_GRN, LAMP_RED};
            PH_Y1:          return {LAMP_YEL, LAMP_RED};
            PH_AR1, PH_AR2: return {LAMP_RED, LAMP_RED};
            PH_G2:          return {LAMP_RED, LAMP_GRN};
            PH_Y2:          return {LAMP_RED, LAMP_YEL};
            PH_FLASH:       return fl ? {LAMP_YEL, LAMP_YEL} : {LAMP_OFF, LAMP_OFF};
            default:        return {LAMP_RED, LAMP_RED};
        endcase
    endfunction

    phase_e           state_q, state_d;
    logic             ped_pend_q, ped_pend_d;
    logic             flash_ph_q, flash_ph_d;
    logic [5:0]       lamps_q, lamps_d;
    phase_e           succ_ph;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_zero;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (RST_REM)
    ) u_timer (
        .clk      (clk),
        .resetn   (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        ped_pend_d   = ped_pend_q | ped_req;
        flash_ph_d   = flash_ph_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = tick_en;
        succ_ph      = next_phase(state_q, ALLRED_EN);

        case (state_q)
            PH_FLASH: begin
                ped_pend_d = 1'b0;
                if (tick_en) begin
                    if (night_mode) begin
                        flash_ph_d = !flash_ph_q;
                    end else begin
                        state_d      = RST_PH;
                        flash_ph_d   = 1'b0;
                        tmr_load     = 1'b1;
                        tmr_load_val = RST_REM;
                    end
                end
            end
            PH_BAD: begin
                state_d      = PH_AR2;
                ped_pend_d   = 1'b0;
                flash_ph_d   = 1'b0;
                tmr_load     = 1'b1;
                tmr_load_val = LD_AR;
            end
            default: begin
                if (tick_en && tmr_zero) begin
                    tmr_load = 1'b1;
                    // Night is only entered where the cycle would hand over to a green
                    if (night_mode && is_green(succ_ph)) begin
                        state_d      = PH_FLASH;
                        flash_ph_d   = 1'b1;
                        ped_pend_d   = 1'b0;
                        tmr_load_val = '0;
                    end else begin
                        state_d      = succ_ph;
                        tmr_load_val = load_value(succ_ph);
                        if ((succ_ph == PH_Y1) || (succ_ph == PH_Y2)) begin
                            ped_pend_d = 1'b0;
                        end
                    end
                end else if (is_green(state_q) && ped_pend_q && (tmr_count > LD_PED)) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_PED;
                end
            end
        endcase

        lamps_d = lamp_of(state_d, flash_ph_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RST_PH;
            ped_pend_q <= 1'b0;
            flash_ph_q <= 1'b0;
            lamps_q    <= lamp_of(RST_PH, 1'b0);
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            flash_ph_q <= flash_ph_d;
            lamps_q    <= lamps_d;
        end
    end

    assign {R1, Y1, G1, R2, Y2, G2} = lamps_q;
    assign remain = tmr_count;
    assign phase  = state_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// tb/tb_traffic_ctrl_param.sv - scoreboard bench for traffic_ctrl_param, with and without all-red phases
module tb_traffic_ctrl_param;

    localparam int CNT_W = 4;
    localparam int TG1   = 4;
    localparam int TG2   = 3;
    localparam int TY    = 2;
    localparam int TPR   = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, tick_en, night_mode, ped_req;
    logic a_r1, a_y1, a_g1, a_r2, a_y2, a_g2;
    logic b_r1, b_y1, b_g1, b_r2, b_y2, b_g2;
    logic [CNT_W-1:0] a_remain, b_remain;
    logic [2:0] a_phase, b_phase;

    traffic_ctrl_param #(
        .CNT_W(CNT_W), .T_GREEN1(TG1), .T_GREEN2(TG2), .T_YELLOW(TY), .T_ALLRED(1), .T_PED_REM(TPR)
    ) dut_a (
        .clk(clk), .reset(reset), .tick_en(tick_en), .night_mode(night_mode), .ped_req(ped_req),
        .R1(a_r1), .Y1(a_y1), .G1(a_g1), .R2(a_r2), .Y2(a_y2), .G2(a_g2),
        .remain(a_remain), .phase(a_phase)
    );

    traffic_ctrl_param #(
        .CNT_W(CNT_W), .T_GREEN1(TG1), .T_GREEN2(TG2), .T_YELLOW(TY), .T_ALLRED(0), .T_PED_REM(TPR)
    ) dut_b (
        .clk(clk), .reset(reset), .tick_en(tick_en), .night_mode(night_mode), .ped_req(ped_req),
        .R1(b_r1), .Y1(b_y1), .G1(b_g1), .R2(b_r2), .Y2(b_y2), .G2(b_g2),
        .remain(b_remain), .phase(b_phase)
    );

    // Reference model: phases 0..5 form a ring G1,Y1,AR1,G2,Y2,AR2; zero-length phases are skipped; 6 is flash
    typedef struct packed { int ph; int rem; bit pend; bit fl; } mstate_t;
    typedef struct packed { int lamps_a; int rem_a; int ph_a; int lamps_b; int rem_b; int ph_b; } exp_t;

    exp_t    exp_q[$];
    mstate_t ma, mb;
    int      obs_a[$], obs_b[$];
    int      checks = 0;
    int      errors = 0;

    function automatic int dur(int ph, int ar);
        case (ph)
            0:       return TG1;
            3:       return TG2;
            1, 4:    return TY;
            2, 5:    return ar;
            default: return 0;
        endcase
    endfunction

    function automatic int succ(int ph, int ar);
        int nx;
        nx = (ph + 1) % 6;
        if (dur(nx, ar) == 0) nx = (nx + 1) % 6;
        return nx;
    endfunction

    function automatic mstate_t mstep(mstate_t s, int ar, bit rst_n, bit tick, bit night, bit ped);
        mstate_t n;
        int      nx;
        n = s;
        if (!rst_n) begin
            n.ph = (ar != 0) ? 5 : 0;
            n.rem = dur(n.ph, ar) - 1;
            n.pend = 1'b0;
            n.fl = 1'b0;
        end else if (s.ph == 6) begin
            n.pend = 1'b0;
            if (tick && night) n.fl = !s.fl;
            else if (tick) begin
                n.ph = (ar != 0) ? 5 : 0;
                n.rem = dur(n.ph, ar) - 1;
                n.fl = 1'b0;
            end
        end else if (tick && s.rem == 0) begin
            nx = succ(s.ph, ar);
            if (night && (nx == 0 || nx == 3)) begin
                n.ph = 6; n.rem = 0; n.fl = 1'b1; n.pend = 1'b0;
            end else begin
                n.ph = nx;
                n.rem = dur(nx, ar) - 1;
                n.pend = (nx == 1 || nx == 4) ? 1'b0 : (s.pend | ped);
            end
        end else begin
            if ((s.ph == 0 || s.ph == 3) && s.pend && s.rem > TPR - 1) n.rem = TPR - 1;
            else if (tick && s.rem > 0) n.rem = s.rem - 1;
            n.pend = s.pend | ped;
        end
        return n;
    endfunction

    // {R1,Y1,G1,R2,Y2,G2}
    function automatic int mlamps(mstate_t s);
        case (s.ph)
            0:       return 6'b001100;
            1:       return 6'b010100;
            3:       return 6'b100001;
            4:       return 6'b100010;
            6:       return s.fl ? 6'b010010 : 6'b000000;
            default: return 6'b100100;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    function automatic bit lamps_legal(logic [5:0] l);
        return ($countones(l[5:3]) <= 1) && ($countones(l[2:0]) <= 1) && !(l[3] && l[0]);
    endfunction

    task automatic step(input bit rst_n, input bit tick, input bit night, input bit ped);
        exp_t e;
        @(negedge clk);
        obs_a.push_back(int'(a_phase));
        obs_b.push_back(int'(b_phase));
        reset = rst_n; tick_en = tick; night_mode = night; ped_req = ped;
        ma = mstep(ma, 1, rst_n, tick, night, ped);
        mb = mstep(mb, 0, rst_n, tick, night, ped);
        e.lamps_a = mlamps(ma); e.rem_a = ma.rem; e.ph_a = ma.ph;
        e.lamps_b = mlamps(mb); e.rem_b = mb.rem; e.ph_b = mb.ph;
        exp_q.push_back(e);
    endtask

    task automatic bound_check(input string name, input bit reached);
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL %s: wait bound expired, actual=0 required=1", name);
        end
    endtask

    // Monitor: every edge that stimulus predicted is compared right after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("lamps_a", int'({a_r1, a_y1, a_g1, a_r2, a_y2, a_g2}), e.lamps_a);
                check("remain_a", int'(a_remain), e.rem_a);
                check("phase_a", int'(a_phase), e.ph_a);
                check("lamps_b", int'({b_r1, b_y1, b_g1, b_r2, b_y2, b_g2}), e.lamps_b);
                check("remain_b", int'(b_remain), e.rem_b);
                check("phase_b", int'(b_phase), e.ph_b);
                check("lamp_rules_a", int'(lamps_legal({a_r1, a_y1, a_g1, a_r2, a_y2, a_g2})), 1);
                check("lamp_rules_b", int'(lamps_legal({b_r1, b_y1, b_g1, b_r2, b_y2, b_g2})), 1);
            end
        end
    end

    initial begin
        int  seq_a[15];
        int  seq_b[15];
        bit  night;
        bit  pulsed;
        seq_a = '{5, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
        seq_b = '{0, 0, 0, 0, 1, 1, 3, 3, 3, 4, 4, 0, 0, 0, 0};
        ma = '0; mb = '0;
        reset = 1'b0; tick_en = 1'b0; night_mode = 1'b0; ped_req = 1'b0;

        // Reset and one full day cycle; phase trace checked against fixed durations
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        obs_a.delete(); obs_b.delete();
        repeat (16) step(1, 1, 0, 0);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("trace_a[%0d]", i), obs_a[i], seq_a[i]);
            check($sformatf("trace_b[%0d]", i), obs_b[i], seq_b[i]);
        end

        // Single ped pulse while G1 shows remain=3
        pulsed = 1'b0;
        for (int i = 0; i < 40 && !pulsed; i++) begin
            if (ma.ph == 0 && ma.rem == 3) begin
                step(1, 1, 0, 1);
                pulsed = 1'b1;
            end else begin
                step(1, 1, 0, 0);
            end
        end
        bound_check("ped_pulse_issued", pulsed);
        repeat (20) step(1, 1, 0, 0);

        // Night mode raised mid-G2, held, then dropped
        for (int i = 0; i < 40 && ma.ph != 3; i++) step(1, 1, 0, 0);
        bound_check("reach_g2", ma.ph == 3);
        step(1, 1, 0, 0);
        repeat (20) step(1, 1, 1, 0);
        repeat (15) step(1, 1, 0, 0);

        // Sparse timebase: tick every third cycle
        for (int i = 0; i < 90; i++) step(1, (i % 3) == 0, 0, 0);

        // Reset mid-Y1, then mid-FLASH
        for (int i = 0; i < 40 && ma.ph != 1; i++) step(1, 1, 0, 0);
        bound_check("reach_y1", ma.ph == 1);
        step(0, 1, 0, 1);
        repeat (5) step(1, 1, 0, 0);
        for (int i = 0; i < 60 && ma.ph != 6; i++) step(1, 1, 1, 0);
        bound_check("reach_flash", ma.ph == 6);
        repeat (3) step(1, 1, 1, 1);
        step(0, 1, 1, 0);
        repeat (10) step(1, 1, 0, 0);

        // Random soak
        night = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) night = !night;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, night, $urandom_range(0, 7) == 0);
        end

        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
